// File: rtl/sw_out_arb.sv
// Packet-aware round-robin output arbiter: merges IN_N upstream beat streams
// into one registered downstream stream, holding the grant until the last beat.

module sw_out_arb #(
    parameter int IN_N  = 5,
    parameter int TAG_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [IN_N-1:0]            upreq_i,
    input  logic [IN_N-1:0][TAG_W-1:0] uptag_i,
    input  logic [IN_N-1:0]            uplast_i,
    output logic [IN_N-1:0]            uprdy_o,
    output logic                       dnreq_o,
    output logic [TAG_W-1:0]           dntag_o,
    output logic                       dnlast_o,
    input  logic                       dnrdy_i,
    output logic [IN_N-1:0]            gnt_o,
    output logic                       busy_o
);

    localparam int IDX_W = (IN_N > 1) ? $clog2(IN_N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IN_N - 1);
    localparam logic [IN_N-1:0]  ONE_HOT0 = {{(IN_N-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic              dnreq_q, dnreq_d;
    logic [TAG_W-1:0]  dntag_q, dntag_d;
    logic              dnlast_q, dnlast_d;

    logic              can_load_s;
    logic [IDX_W:0]    pick_s;
    logic              sel_vld_s;
    logic [IDX_W-1:0]  sel_idx_s;
    logic [IN_N-1:0]   sel_oh_s;
    logic              xfer_s;
    logic              xfer_last_s;

    // Returns {found, index} of the first request at or after ptr, wrapping.
    // Scanning from the farthest offset down lets the nearest one win last.
    function automatic logic [IDX_W:0] rr_pick(input logic [IN_N-1:0]  req,
                                               input logic [IDX_W-1:0] ptr);
        logic [IDX_W:0] res;
        int             j;
        res = '0;
        for (int k = IN_N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= IN_N) begin
                j = j - IN_N;
            end
            if (req[j]) begin
                res = {1'b1, IDX_W'(j)};
            end
        end
        return res;
    endfunction

    // Grant selection and upstream handshake.
    always_comb begin
        pick_s     = rr_pick(upreq_i, rr_ptr_q);
        can_load_s = ~dnreq_q | dnrdy_i;
        if (state_q == ST_LOCK) begin
            sel_vld_s = 1'b1;
            sel_idx_s = owner_q;
        end else begin
            sel_vld_s = pick_s[IDX_W];
            sel_idx_s = pick_s[IDX_W-1:0];
        end
        sel_oh_s = ONE_HOT0 << sel_idx_s;
        if (rst) begin
            gnt_o   = '0;
            uprdy_o = '0;
        end else begin
            gnt_o   = sel_vld_s ? sel_oh_s : '0;
            uprdy_o = (sel_vld_s && can_load_s) ? sel_oh_s : '0;
        end
        xfer_s      = |(upreq_i & uprdy_o);
        xfer_last_s = xfer_s & uplast_i[sel_idx_s];
    end

    // Next-state, round-robin pointer and output-register load.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        dnreq_d  = dnreq_q;
        dntag_d  = dntag_q;
        dnlast_d = dnlast_q;

        case (state_q)
            ST_IDLE: begin
                if (xfer_s && !xfer_last_s) begin
                    state_d = ST_LOCK;
                    owner_d = sel_idx_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCK: begin
                if (xfer_last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LOCK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (xfer_last_s) begin
            rr_ptr_d = (sel_idx_s == LAST_IDX) ? '0 : sel_idx_s + IDX_W'(1);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end

        // A new beat may overwrite the register in the same cycle it drains.
        if (xfer_s) begin
            dnreq_d  = 1'b1;
            dntag_d  = uptag_i[sel_idx_s];
            dnlast_d = uplast_i[sel_idx_s];
        end else if (dnrdy_i) begin
            dnreq_d = 1'b0;
        end else begin
            dnreq_d = dnreq_q;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            dnreq_q  <= 1'b0;
            dntag_q  <= '0;
            dnlast_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            dnreq_q  <= dnreq_d;
            dntag_q  <= dntag_d;
            dnlast_q <= dnlast_d;
        end
    end

    assign dnreq_o  = dnreq_q;
    assign dntag_o  = dntag_q;
    assign dnlast_o = dnlast_q;
    assign busy_o   = (state_q == ST_LOCK);

    sw_out_arb_chk #(
        .IN_N  (IN_N),
        .TAG_W (TAG_W)
    ) u_chk (
        .clk     (clk),
        .rst     (rst),
        .uprdy_i (uprdy_o),
        .dnreq_i (dnreq_q),
        .dnrdy_i (dnrdy_i),
        .dntag_i (dntag_q),
        .dnlast_i(dnlast_q)
    );

endmodule

// Protocol checker: single-ready and stable-output-under-backpressure rules.
module sw_out_arb_chk #(
    parameter int IN_N  = 5,
    parameter int TAG_W = 32
) (
    input logic             clk,
    input logic             rst,
    input logic [IN_N-1:0]  uprdy_i,
    input logic             dnreq_i,
    input logic             dnrdy_i,
    input logic [TAG_W-1:0] dntag_i,
    input logic             dnlast_i
);

    logic             hold_q;
    logic [TAG_W-1:0] tag_prev_q;
    logic             last_prev_q;

    // Remember whether the previous cycle was stalled and what it presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q      <= 1'b0;
            tag_prev_q  <= '0;
            last_prev_q <= 1'b0;
        end else begin
            hold_q      <= dnreq_i & ~dnrdy_i;
            tag_prev_q  <= dntag_i;
            last_prev_q <= dnlast_i;
        end
    end

    // Evaluate the rules on every edge outside reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_rdy_onehot0: assert ($onehot0(uprdy_i))
                else $error("uprdy not one-hot-or-zero: %b", uprdy_i);
            if (hold_q) begin
                a_hold_stable: assert (dnreq_i && dntag_i == tag_prev_q && dnlast_i == last_prev_q)
                    else $error("downstream beat changed while stalled");
            end
        end
    end

endmodule

// File: tb/tb_sw_out_arb.sv
// Directed bench for sw_out_arb: per-step grant/ready checks plus a beat
// scoreboard fed from expected grants and drained on downstream handshakes.

module tb_sw_out_arb;

    localparam int IN_N  = 5;
    localparam int TAG_W = 32;

    logic                       clk;
    logic                       rst;
    logic [IN_N-1:0]            upreq_i;
    logic [IN_N-1:0][TAG_W-1:0] uptag_i;
    logic [IN_N-1:0]            uplast_i;
    logic [IN_N-1:0]            uprdy_o;
    logic                       dnreq_o;
    logic [TAG_W-1:0]           dntag_o;
    logic                       dnlast_o;
    logic                       dnrdy_i;
    logic [IN_N-1:0]            gnt_o;
    logic                       busy_o;

    int n_assert = 0;
    int n_fail   = 0;

    logic [TAG_W:0] sb[$];

    sw_out_arb #(
        .IN_N  (IN_N),
        .TAG_W (TAG_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .upreq_i (upreq_i),
        .uptag_i (uptag_i),
        .uplast_i(uplast_i),
        .uprdy_o (uprdy_o),
        .dnreq_o (dnreq_o),
        .dntag_o (dntag_o),
        .dnlast_o(dnlast_o),
        .dnrdy_i (dnrdy_i),
        .gnt_o   (gnt_o),
        .busy_o  (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Tag of input i for a step with the given base value.
    function automatic logic [TAG_W-1:0] tag_of(input logic [TAG_W-1:0] base, input int i);
        return base ^ (32'(i) << 28);
    endfunction

    // One clock cycle: drive at negedge, check combinational and registered
    // outputs 1 time unit later, retire any downstream beat, queue new beats.
    task automatic step(input logic            r,
                        input logic [IN_N-1:0] req,
                        input logic [IN_N-1:0] last,
                        input logic            rdy,
                        input logic [TAG_W-1:0] base,
                        input logic [IN_N-1:0] exp_gnt,
                        input logic [IN_N-1:0] exp_rdy,
                        input logic            exp_dnreq,
                        input logic            exp_busy);
        logic [TAG_W:0] e;
        @(negedge clk);
        rst      = r;
        upreq_i  = req;
        uplast_i = last;
        dnrdy_i  = rdy;
        for (int i = 0; i < IN_N; i++) uptag_i[i] = tag_of(base, i);
        #1;
        chk("gnt",   64'(gnt_o),   64'(exp_gnt));
        chk("uprdy", 64'(uprdy_o), 64'(exp_rdy));
        chk("dnreq", 64'(dnreq_o), 64'(exp_dnreq));
        chk("busy",  64'(busy_o),  64'(exp_busy));
        if (dnreq_o && dnrdy_i) begin
            chk("sb_nonempty", 64'(sb.size() > 0), 64'(1));
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("dn_tag",  64'(dntag_o),  64'(e[TAG_W-1:0]));
                chk("dn_last", 64'(dnlast_o), 64'(e[TAG_W]));
            end
        end
        if (r) begin
            sb.delete();
        end else begin
            for (int i = 0; i < IN_N; i++) begin
                if (exp_rdy[i] && req[i]) sb.push_back({last[i], tag_of(base, i)});
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        upreq_i  = '0;
        uplast_i = '0;
        dnrdy_i  = 1'b0;
        uptag_i  = '0;
        repeat (2) @(posedge clk);

        // Reset: outputs cleared, grants suppressed even with requests pending.
        step(1'b1, 5'b11111, 5'b11111, 1'b1, 32'h0, 5'b00000, 5'b00000, 1'b0, 1'b0);
        chk("rst_tag",  64'(dntag_o),  64'(0));
        chk("rst_last", 64'(dnlast_o), 64'(0));

        // Single-beat fairness: 0,1,2,3,4,0 with a beat every cycle.
        step(1'b0, 5'b11111, 5'b11111, 1'b1, 32'h10, 5'b00001, 5'b00001, 1'b0, 1'b0);
        step(1'b0, 5'b11111, 5'b11111, 1'b1, 32'h11, 5'b00010, 5'b00010, 1'b1, 1'b0);
        step(1'b0, 5'b11111, 5'b11111, 1'b1, 32'h12, 5'b00100, 5'b00100, 1'b1, 1'b0);
        step(1'b0, 5'b11111, 5'b11111, 1'b1, 32'h13, 5'b01000, 5'b01000, 1'b1, 1'b0);
        step(1'b0, 5'b11111, 5'b11111, 1'b1, 32'h14, 5'b10000, 5'b10000, 1'b1, 1'b0);
        step(1'b0, 5'b11111, 5'b11111, 1'b1, 32'h15, 5'b00001, 5'b00001, 1'b1, 1'b0);
        step(1'b0, 5'b00000, 5'b00000, 1'b1, 32'h16, 5'b00000, 5'b00000, 1'b1, 1'b0);

        // Packet lock: input 2 sends A,B,C while input 3 waits; then input 3.
        step(1'b0, 5'b01100, 5'b01000, 1'b1, 32'hA, 5'b00100, 5'b00100, 1'b0, 1'b0);
        step(1'b0, 5'b01100, 5'b01000, 1'b1, 32'hB, 5'b00100, 5'b00100, 1'b1, 1'b1);
        step(1'b0, 5'b01100, 5'b01100, 1'b1, 32'hC, 5'b00100, 5'b00100, 1'b1, 1'b1);
        chk("lock_tag_B", 64'(dntag_o), 64'(tag_of(32'hB, 2)));
        step(1'b0, 5'b01100, 5'b01100, 1'b1, 32'hD, 5'b01000, 5'b01000, 1'b1, 1'b0);
        chk("lock_tag_C", 64'(dntag_o), 64'(tag_of(32'hC, 2)));
        step(1'b0, 5'b00000, 5'b00000, 1'b1, 32'hE, 5'b00000, 5'b00000, 1'b1, 1'b0);

        // Backpressure: beat 0x55 held for 4 stalled cycles, then 0x77 follows.
        step(1'b0, 5'b00001, 5'b00001, 1'b1, 32'h55, 5'b00001, 5'b00001, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 5'b00001, 5'b00001, 1'b0, 32'h66, 5'b00001, 5'b00000, 1'b1, 1'b0);
            chk("bp_tag", 64'(dntag_o), 64'(32'h55));
        end
        step(1'b0, 5'b00001, 5'b00001, 1'b1, 32'h77, 5'b00001, 5'b00001, 1'b1, 1'b0);
        step(1'b0, 5'b00000, 5'b00000, 1'b1, 32'h78, 5'b00000, 5'b00000, 1'b1, 1'b0);
        chk("bp_next_tag", 64'(dntag_o), 64'(32'h77));

        // Owner gap: input 1 locked, drops its request for 3 cycles.
        step(1'b0, 5'b00011, 5'b00000, 1'b1, 32'h100, 5'b00010, 5'b00010, 1'b0, 1'b0);
        step(1'b0, 5'b00001, 5'b00000, 1'b1, 32'h101, 5'b00010, 5'b00010, 1'b1, 1'b1);
        step(1'b0, 5'b00001, 5'b00000, 1'b1, 32'h102, 5'b00010, 5'b00010, 1'b0, 1'b1);
        step(1'b0, 5'b00001, 5'b00000, 1'b1, 32'h103, 5'b00010, 5'b00010, 1'b0, 1'b1);
        step(1'b0, 5'b00011, 5'b00010, 1'b1, 32'h200, 5'b00010, 5'b00010, 1'b0, 1'b1);
        step(1'b0, 5'b00000, 5'b00000, 1'b1, 32'h201, 5'b00000, 5'b00000, 1'b1, 1'b0);

        // Reset mid-packet of input 4 with a stalled beat held.
        step(1'b0, 5'b10000, 5'b00000, 1'b1, 32'h300, 5'b10000, 5'b10000, 1'b0, 1'b0);
        step(1'b0, 5'b10000, 5'b00000, 1'b0, 32'h301, 5'b10000, 5'b00000, 1'b1, 1'b1);
        step(1'b1, 5'b10001, 5'b10001, 1'b0, 32'h302, 5'b00000, 5'b00000, 1'b1, 1'b1);
        step(1'b0, 5'b10001, 5'b10001, 1'b1, 32'h400, 5'b00001, 5'b00001, 1'b0, 1'b0);
        step(1'b0, 5'b10001, 5'b10001, 1'b1, 32'h500, 5'b10000, 5'b10000, 1'b1, 1'b0);
        step(1'b0, 5'b00000, 5'b00000, 1'b1, 32'h501, 5'b00000, 5'b00000, 1'b1, 1'b0);
        step(1'b0, 5'b00000, 5'b00000, 1'b1, 32'h502, 5'b00000, 5'b00000, 1'b0, 1'b0);
        chk("sb_drained", 64'(sb.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sw_out_arb.md
SW_OUT_ARB -- requirements
Module: sw_out_arb

Interface
REQ-001 SHALL have parameter IN_N, default 5, giving the number of upstream requesters.
REQ-002 SHALL have parameter TAG_W, default 32, giving the payload/tag width.
REQ-003 SHALL have port clk  input  1  single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port upreq_i  input  IN_N  per-requester beat valid.
REQ-006 SHALL have port uptag_i  input  IN_N x TAG_W  per-requester beat payload.
REQ-007 SHALL have port uplast_i  input  IN_N  per-requester last-beat-of-packet flag.
REQ-008 SHALL have port uprdy_o  output  IN_N  per-requester ready.
REQ-009 SHALL have port dnreq_o  output  1  downstream beat valid, registered.
REQ-010 SHALL have port dntag_o  output  TAG_W  downstream payload, registered.
REQ-011 SHALL have port dnlast_o  output  1  downstream last flag, registered.
REQ-012 SHALL have port dnrdy_i  input  1  downstream ready.
REQ-013 SHALL have port gnt_o  output  IN_N  one-hot current owner; zero when no owner.
REQ-014 SHALL have port busy_o  output  1  high while in the LOCK state.

Function
REQ-015 SHALL define a beat transfer upstream as upreq_i[i] & uprdy_o[i], and downstream as dnreq_o & dnrdy_i.
REQ-016 SHALL implement a two-state FSM: IDLE (no owner) and LOCK (owner held mid-packet).
REQ-017 SHALL define can_load = ~dnreq_o | dnrdy_i, meaning the output register is empty or draining this cycle.
REQ-018 In IDLE, SHALL combinationally pick a winner: the first asserted upreq_i index at or after rr_ptr, searching upward modulo IN_N.
REQ-019 In IDLE, SHALL assert uprdy_o only for the winner, and only when can_load is high; gnt_o SHALL equal the winner one-hot, or zero if no requests.
REQ-020 In LOCK, SHALL assert uprdy_o only for the owner when can_load is high; gnt_o SHALL equal the owner; requests from other inputs SHALL be ignored.
REQ-021 SHALL never assert more than one uprdy_o bit in a cycle.
REQ-022 On an IDLE transfer with uplast_i=0, SHALL move to LOCK with owner = winner.
REQ-023 On an IDLE transfer with uplast_i=1 (single-beat packet), SHALL stay in IDLE.
REQ-024 On a LOCK transfer with uplast_i=1, SHALL return to IDLE.
REQ-025 SHALL update rr_ptr to (granted index + 1) mod IN_N only on a transfer with uplast_i=1; otherwise rr_ptr holds.
REQ-026 On an upstream transfer, SHALL load dntag_o and dnlast_o from the granted input and set dnreq_o=1 on the next edge; latency is 1 cycle.
REQ-027 When dnreq_o & dnrdy_i and no upstream transfer occurs, SHALL clear dnreq_o on the next edge.
REQ-028 When dnrdy_i and an upstream transfer occur in the same cycle, SHALL keep dnreq_o=1 and replace the data, sustaining 1 beat/cycle.
REQ-029 When dnreq_o & ~dnrdy_i, SHALL hold dntag_o, dnlast_o and dnreq_o stable and deassert all uprdy_o.
REQ-030 If the owner drops upreq_i in LOCK, SHALL stay in LOCK and wait; no other input is granted (no timeout).
REQ-031 uprdy_o SHALL depend combinationally on dnrdy_i; there is no other combinational path from upstream inputs to downstream outputs.

Reset
REQ-032 SHALL, while rst=1 at an edge, set state=IDLE, rr_ptr=0, owner=0, dnreq_o=0, dnlast_o=0, dntag_o=0.
REQ-033 SHALL force uprdy_o=0 and gnt_o=0 combinationally while rst=1.
REQ-034 SHALL, on reset mid-packet, discard the lock and any held output beat; arbitration SHALL restart from index 0 in the first cycle after reset.

Verification
REQ-035 SHALL test single-beat fairness: upreq_i=5'b11111, all uplast_i=1, dnrdy_i=1 -> grants 0,1,2,3,4,0; dnreq_o=1 every cycle from cycle 1 on.
REQ-036 SHALL test packet lock: input 2 sends a 3-beat packet (tags A,B,C, last on C) while input 3 requests -> dntag_o=A,B,C consecutively, then input 3 granted; rr_ptr=3 after C.
REQ-037 SHALL test backpressure: dnrdy_i=0 for 4 cycles with dnreq_o=1, tag=0x55 -> dntag_o stays 0x55, uprdy_o=0 throughout; after dnrdy_i=1, the next beat follows in the following cycle.
REQ-038 SHALL test an owner gap: input 1 in LOCK drops upreq_i for 3 cycles while input 0 requests -> gnt_o stays 5'b00010 and no beat from input 0 appears.
REQ-039 SHALL test reset mid-packet: rst=1 during LOCK of input 4 -> next cycle busy_o=0, dnreq_o=0; with upreq_i=5'b10001, input 0 is granted first.
REQ-040 SHALL check with assertions that uprdy_o is one-hot or zero, and that dntag_o is stable while dnreq_o & ~dnrdy_i.
